// File: rtl/serial_alu_ctrl.sv
// -----------------------------------------------------------------------------
// serial_alu_ctrl
//
// Runs a full-width ALU operation through one 1-bit ALU slice, one bit per
// clock, LSB first. Operands and the control code are latched on an accepted
// start. The slice result is shifted into a shift register, and the final
// result and flags are published when the operation completes.
//
// Supported ALU_control codes:
//   0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
//   Any other code completes with the same latency and gives result = 0,
//   zero = 1, cout = 0 and overflow = 0.
//
// Optional feature (compile-time macro SERIAL_ALU_ABORT_EN):
//   Adds input 'abort'. abort=1 while in RUN returns the FSM to IDLE on the
//   next edge. No done pulse is produced, and result/flags keep their
//   pre-operation values. The default build leaves the port out.
//
// Handshake:
//   start is sampled only in IDLE. An accepted start raises busy on that edge.
//   busy stays high through RUN (WIDTH cycles) and DONE (1 cycle).
//   done is a one-cycle pulse in DONE. result/zero/cout/overflow are valid
//   from done and are held until the next operation's DONE. start while busy
//   is ignored, and nothing is queued.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        operation request (IDLE only)
//   src1, src2   operands A and B, sampled with start
//   ALU_control  4-bit operation code, sampled with start
//   abort        (SERIAL_ALU_ABORT_EN only) cancel the running operation
//   busy         high in RUN and DONE
//   done         one-cycle completion pulse
//   result       final result
//   zero         result == 0
//   cout         carry out of the MSB for ADD/SUB/SLT, else 0
//   overflow     signed overflow for ADD/SUB/SLT, else 0
//   o_dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE), for observation
// -----------------------------------------------------------------------------
module serial_alu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
`ifdef SERIAL_ALU_ABORT_EN
  input  logic             abort,
`else
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;       // operand A, shifted right so bit i is at [0] in cycle i
  logic [WIDTH-1:0] r_b;       // operand B, same arrangement
  logic             r_ainv;
  logic             r_binv;
  logic [1:0]       r_op;
  logic             r_valid;   // latched code is one of the six supported ones
  logic             r_arith;   // ADD/SUB/SLT: the flags are meaningful
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_shift;

  // ---------------------------------------------------------------------------
  // Code decode at acceptance time
  // ---------------------------------------------------------------------------
  logic w_code_valid;

  always_comb begin
    w_code_valid = 1'b0;
    case (ALU_control)
      4'b0000, 4'b0001, 4'b0010,
      4'b0110, 4'b0111, 4'b1100: w_code_valid = 1'b1;
      default:                   w_code_valid = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // 1-bit ALU slice
  // ---------------------------------------------------------------------------
  logic w_a;
  logic w_b;
  logic w_sum;
  logic w_slice_cout;
  logic w_res_bit;

  always_comb begin
    w_a          = r_a[0] ^ r_ainv;
    w_b          = r_b[0] ^ r_binv;
    w_sum        = w_a ^ w_b ^ r_carry;
    w_slice_cout = (w_a & w_b) | (r_carry & (w_a ^ w_b));
    w_res_bit    = 1'b0;
    case (r_op)
      2'b00:   w_res_bit = w_a & w_b;
      2'b01:   w_res_bit = w_a | w_b;
      2'b10:   w_res_bit = w_sum;
      default: w_res_bit = 1'b0;   // SLT: less input is tied to 0 on every bit
    endcase
  end

  // ---------------------------------------------------------------------------
  // Completion values.
  // On the last RUN cycle the slice is working on the MSB, so r_carry is
  // cin_msb, w_slice_cout is cout_msb and w_sum is sum_msb. They are used
  // directly on the edge that enters DONE, so they need no extra registers.
  // ---------------------------------------------------------------------------
  logic             w_last;
  logic [WIDTH-1:0] w_shift_full;
  logic             w_ovf;
  logic             w_cout_f;
  logic [WIDTH-1:0] w_final;

  always_comb begin
    w_last       = (r_cnt == LAST_BIT);
    w_shift_full = {w_res_bit, r_shift[WIDTH-1:1]};
    w_ovf        = r_arith & (r_carry ^ w_slice_cout);
    w_cout_f     = r_arith & w_slice_cout;
    w_final      = '0;
    if (!r_valid) begin
      w_final = '0;
    end else if (r_op == 2'b11) begin
      // SLT: the sign of A-B corrected for overflow gives "A < B"
      w_final[0] = w_sum ^ w_ovf;
    end else begin
      w_final = w_shift_full;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_ainv   <= 1'b0;
      r_binv   <= 1'b0;
      r_op     <= 2'b00;
      r_valid  <= 1'b0;
      r_arith  <= 1'b0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_shift  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b1;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= src1;
            r_b     <= src2;
            r_ainv  <= ALU_control[3];
            r_binv  <= ALU_control[2];
            r_op    <= ALU_control[1:0];
            r_valid <= w_code_valid;
            r_arith <= w_code_valid & ALU_control[1];
            r_cnt   <= '0;
            // SUB/SLT get their +1 from the carry-in of bit 0
            r_carry <= ALU_control[2];
            r_shift <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
`ifdef SERIAL_ALU_ABORT_EN
          if (abort) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
`else
          begin
`endif
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_shift <= w_shift_full;
            r_carry <= w_slice_cout;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
              result   <= w_final;
              zero     <= (w_final == '0);
              cout     <= w_cout_f;
              overflow <= w_ovf;
              done     <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for serial_alu_ctrl (WIDTH = 32).
// It uses an arithmetic reference model of the ALU codes, a scoreboard queue
// of expected {overflow, cout, zero, result}, directed corner operations,
// randomized operations, a start-held-high check and a mid-run reset.
// When SERIAL_ALU_ABORT_EN is defined, it also runs an abort check.
// -----------------------------------------------------------------------------
module tb_serial_alu_ctrl;
  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic [3:0]   ALU_control;
`ifdef SERIAL_ALU_ABORT_EN
  logic         abort;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         cout;
  logic         overflow;
  logic [1:0]   o_dbg_state;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .src1        (src1),
    .src2        (src2),
    .ALU_control (ALU_control),
`ifdef SERIAL_ALU_ABORT_EN
    .abort       (abort),
`endif
    .busy        (busy),
    .done        (done),
    .result      (result),
    .zero        (zero),
    .cout        (cout),
    .overflow    (overflow),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W+2:0] exp_q[$];      // {overflow, cout, zero, result}
  logic [W-1:0] last_res;      // result the DUT must currently hold
  int           n_checks = 0;
  int           n_bad    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] c);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    logic         lt;
    r  = '0;
    co = 1'b0;
    ov = 1'b0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'b0110, 4'b0111: begin
        s  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        if (c == 4'b0111) begin
          lt = ($signed(a) < $signed(b));
          r  = {{(W-1){1'b0}}, lt};
        end
      end
      default: r = '0;
    endcase
    return {ov, co, (r == '0), r};
  endfunction

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] rand_code();
    logic [3:0] codes [6];
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    if ($urandom_range(0, 7) == 0) return 4'($urandom);
    return codes[$urandom_range(0, 5)];
  endfunction

  // ---------------------------------------------------------------------------
  // Driver task: issues one operation and checks latency, hold and outputs
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    int           k;
    logic [W+2:0] e;
    @(negedge clk);
    src1 = a; src2 = b; ALU_control = c; start = 1'b1;
    exp_q.push_back(model(a, b, c));
    @(negedge clk);
    // Scramble the inputs after acceptance; the op must use the latched values.
    start = 1'b0; src1 = $urandom; src2 = $urandom; ALU_control = 4'($urandom);
    check("busy_in_run", busy, 1);
    k = 0;
    while (done !== 1'b1 && k < W + 4) begin
      if (k == W / 2) check("result_hold_in_run", result, last_res);
      @(negedge clk);
      k++;
    end
    check("done_latency", k, W);
    e = exp_q.pop_front();
    check("result", result, e[W-1:0]);
    check("zero", zero, e[W]);
    check("cout", cout, e[W+1]);
    check("overflow", overflow, e[W+2]);
    last_res = e[W-1:0];
    @(negedge clk);
    check("done_single", done, 0);
    check("busy_after", busy, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [W+2:0] e;
    logic [W-1:0] a2;
    logic [W-1:0] b2;
    int           dones;
    int           k;

    rst_n = 1'b0; start = 1'b0; src1 = '0; src2 = '0; ALU_control = '0;
`ifdef SERIAL_ALU_ABORT_EN
    abort = 1'b0;
`endif
    last_res = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_cout", cout, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;

    // Directed corner operations
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010);
    run_op(32'h0000_0005, 32'h0000_0005, 4'b0110);
    run_op(32'h0000_0000, 32'h0000_0000, 4'b1100);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b0111);
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 4'b0111);
    run_op(32'h1234_5678, 32'h0F0F_0F0F, 4'b0101);
    run_op(32'hA5A5_0000, 32'h0000_5A5A, 4'b0001);

    // Randomized operations
    for (int i = 0; i < 30; i++) run_op(rand_opnd(), rand_opnd(), rand_code());

    // start held for 40 cycles. Operands keep changing early, then settle, so
    // the second (legitimately accepted) op has well-defined operands.
    a2 = $urandom; b2 = $urandom;
    @(negedge clk);
    src1 = 32'h0000_FFFF; src2 = 32'h0000_0001; ALU_control = 4'b0010; start = 1'b1;
    e = model(32'h0000_FFFF, 32'h0000_0001, 4'b0010);
    dones = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        check("held_start_result", result, e[W-1:0]);
        check("held_start_cycle", j, W);
      end
      if (j < 25) begin
        src1 = $urandom; src2 = $urandom; ALU_control = rand_code();
      end else begin
        src1 = a2; src2 = b2; ALU_control = 4'b0001;
      end
    end
    start = 1'b0;
    check("held_start_done_count", dones, 1);
    e = model(a2, b2, 4'b0001);
    k = 0;
    while (done !== 1'b1 && k < 2 * W) begin
      @(negedge clk);
      k++;
    end
    check("second_op_result", result, e[W-1:0]);
    last_res = e[W-1:0];
    @(negedge clk);

    // Nonzero result ahead of the reset test
    run_op(32'h0000_0000, 32'h0000_0000, 4'b1100);

    // Reset asserted at RUN bit 10
    @(negedge clk);
    src1 = 32'h1111_1111; src2 = 32'h2222_2222; ALU_control = 4'b0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_result", result, 0);
    check("midrun_rst_zero", zero, 1);
    check("midrun_rst_done", done, 0);
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("no_done_after_rst", dones, 0);
    run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000);

`ifdef SERIAL_ALU_ABORT_EN
    // Abort at RUN bit 5. No done pulse, and the previous result is held.
    run_op(32'h0000_0003, 32'h0000_0004, 4'b0010);
    @(negedge clk);
    src1 = 32'hFFFF_FFFF; src2 = 32'h0000_0001; ALU_control = 4'b0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    dones = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_result_kept", result, last_res);
    check("abort_zero_kept", zero, (last_res == '0));
    run_op(32'h0000_0009, 32'h0000_0002, 4'b0110);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
